// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counting timer with one-cycle done pulse and optional auto-reload
module down_counter_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] count_nx, reload;

    assign busy = (state == RUN) || (state == PAUSE);
    assign done = state == DONE;
    assign zero = count == '0;

    // next state and count; load overrides everything, then start, then en
    always_comb begin
        state_nx = state;
        count_nx = count;
        if (load) begin
            count_nx = load_val;
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nx = zero ? DONE : RUN;
                RUN, PAUSE: begin
                    if (en) begin
                        count_nx = zero ? count : count - 1'b1;
                        state_nx = (count <= WIDTH'(1)) ? DONE : RUN;
                    end else begin
                        state_nx = PAUSE;
                    end
                end
                default: begin
                    count_nx = (AUTO_RELOAD && reload != '0) ? reload : count;
                    state_nx = (AUTO_RELOAD && reload != '0) ? RUN : IDLE;
                end
            endcase
        end
    end

    // state, count and reload registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            if (load) reload <= load_val;
        end
    end
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed scoreboard bench for down_counter_timer (one plain, one auto-reload instance)
module tb_down_counter_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en0 = 0, load0 = 0, start0 = 0;
    logic [3:0] lv0 = '0;
    logic [3:0] count0;
    logic       busy0, done0, zero0;
    logic       en1 = 0, load1 = 0, start1 = 0;
    logic [3:0] lv1 = '0;
    logic [3:0] count1;
    logic       busy1, done1, zero1;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        string      tag;
        bit         sel;
        logic [6:0] v;
    } exp_t;
    exp_t q[$];

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .load(load0), .load_val(lv0), .start(start0),
        .count(count0), .busy(busy0), .done(done0), .zero(zero0)
    );

    down_counter_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .load(load1), .load_val(lv1), .start(start1),
        .count(count1), .busy(busy1), .done(done1), .zero(zero1)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input bit sel, input int c, input bit b, input bit d);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = {4'(c), b, d, (c == 0)};
        q.push_back(e);
    endtask

    task automatic check_all();
        exp_t       e;
        logic [6:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = e.sel ? {count1, busy1, done1, zero1} : {count0, busy0, done0, zero0};
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: count=%0d busy=%0b done=%0b zero=%0b expected count=%0d busy=%0b done=%0b zero=%0b",
                       e.tag, obs[6:3], obs[2], obs[1], obs[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
            end
        end
    endtask

    task automatic step(input string tag, input bit sel, input int c, input bit b, input bit d);
        push(tag, sel, c, b, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #3;
        push("reset0", 0, 0, 0, 0);
        push("reset1", 1, 0, 0, 0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        // test 1: load 5, countdown with en held
        lv0 = 4'd5; load0 = 1;
        step("t1_load", 0, 5, 0, 0);
        load0 = 0; start0 = 1; en0 = 1;
        step("t1_start", 0, 5, 1, 0);
        start0 = 0;
        for (int i = 4; i >= 1; i--) step("t1_dec", 0, i, 1, 0);
        step("t1_zero_done", 0, 0, 0, 1);
        step("t1_idle", 0, 0, 0, 0);
        // test 2: pause while en low
        lv0 = 4'd3; load0 = 1; en0 = 0;
        step("t2_load", 0, 3, 0, 0);
        load0 = 0; start0 = 1; en0 = 1;
        step("t2_start", 0, 3, 1, 0);
        start0 = 0;
        step("t2_dec", 0, 2, 1, 0);
        en0 = 0;
        for (int i = 0; i < 3; i++) step("t2_pause", 0, 2, 1, 0);
        en0 = 1;
        step("t2_resume", 0, 1, 1, 0);
        step("t2_done", 0, 0, 0, 1);
        step("t2_idle", 0, 0, 0, 0);
        // test 3: start with count 0 after reset
        en0 = 0;
        rst = 0;
        #1;
        push("t3_reset", 0, 0, 0, 0);
        check_all();
        rst = 1;
        start0 = 1;
        step("t3_done", 0, 0, 0, 1);
        start0 = 0;
        step("t3_idle", 0, 0, 0, 0);
        // test 5: load beats start, then async reset mid-run
        lv0 = 4'd7; load0 = 1; start0 = 1;
        step("t5_load_wins", 0, 7, 0, 0);
        load0 = 0; en0 = 1;
        step("t5_start", 0, 7, 1, 0);
        start0 = 0;
        for (int i = 6; i >= 4; i--) step("t5_dec", 0, i, 1, 0);
        rst = 0;
        #2;
        push("t5_async_rst", 0, 0, 0, 0);
        check_all();
        rst = 1;
        step("t5_no_done", 0, 0, 0, 0);
        // test 6: full-scale load, no wrap below zero
        lv0 = 4'd15; load0 = 1;
        step("t6_load", 0, 15, 0, 0);
        load0 = 0; start0 = 1;
        step("t6_start", 0, 15, 1, 0);
        start0 = 0;
        for (int i = 14; i >= 1; i--) step("t6_dec", 0, i, 1, 0);
        step("t6_done", 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("t6_hold", 0, 0, 0, 0);
        en0 = 0;
        // test 4: auto-reload periodic ticks, then load during run
        lv1 = 4'd2; load1 = 1;
        step("t4_load", 1, 2, 0, 0);
        load1 = 0; start1 = 1; en1 = 1;
        step("t4_start", 1, 2, 1, 0);
        start1 = 0;
        for (int p = 0; p < 2; p++) begin
            step("t4_dec", 1, 1, 1, 0);
            step("t4_done", 1, 0, 0, 1);
            step("t4_reload", 1, 2, 1, 0);
        end
        lv1 = 4'd9; load1 = 1;
        step("t4_load_run", 1, 9, 0, 0);
        load1 = 0;
        step("t4_idle_hold", 1, 9, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
